// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: one shared multiplier is stepped across all taps per
// accepted sample, then the sum is shifted, saturated and offered on a valid/ready output.
module fir_mac_sequencer #(
  parameter int unsigned TAPS  = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned CW    = 8,
  parameter int unsigned SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [CW-1:0]            coef_data,
  output logic                     coef_ack,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data
);

  localparam int unsigned AW    = $clog2(TAPS);
  localparam int unsigned PW    = DW + CW;
  localparam int unsigned ACC_W = DW + CW + AW;

  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;
  localparam logic [AW-1:0]           LAST_TAP = AW'(TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_ROUND = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                   r_state;
  logic signed [CW-1:0]     r_coef [TAPS];
  logic signed [DW-1:0]     r_x    [TAPS];
  logic [AW-1:0]            r_wr_ptr;
  logic [AW-1:0]            r_newest;
  logic [AW-1:0]            r_k;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_out_valid;
  logic [DW-1:0]            r_out_data;
  logic                     r_coef_ack;

  state_t                   w_state_nxt;
  logic [AW-1:0]            w_k_nxt;
  logic signed [ACC_W-1:0]  w_acc_nxt;
  logic                     w_out_valid_nxt;
  logic [DW-1:0]            w_out_data_nxt;
  logic                     w_in_ready;
  logic                     w_accept_in;
  logic                     w_accept_coef;

  logic [AW-1:0]            w_tap_idx;
  logic signed [PW-1:0]     w_coef_ext;
  logic signed [PW-1:0]     w_x_ext;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_shifted;
  logic signed [ACC_W-1:0]  w_sat;

  // Tap k reads the sample k positions older than the newest one; AW-bit math wraps mod TAPS.
  assign w_tap_idx  = r_newest - r_k;
  assign w_coef_ext = PW'(r_coef[r_k]);
  assign w_x_ext    = PW'(r_x[w_tap_idx]);
  assign w_prod     = w_coef_ext * w_x_ext;

  assign w_shifted  = r_acc >>> SHIFT;

  always_comb begin
    w_sat = w_shifted;
    if (w_shifted > SAT_MAX) begin
      w_sat = SAT_MAX;
    end else if (w_shifted < SAT_MIN) begin
      w_sat = SAT_MIN;
    end
  end

  // Next-state and datapath control; ena low leaves every register at its current value.
  always_comb begin
    w_state_nxt     = r_state;
    w_k_nxt         = r_k;
    w_acc_nxt       = r_acc;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_in_ready      = 1'b0;
    w_accept_in     = 1'b0;
    w_accept_coef   = 1'b0;
    if (ena) begin
      case (r_state)
        S_IDLE: begin
          w_in_ready    = 1'b1;
          w_accept_coef = coef_we;
          if (in_valid) begin
            w_accept_in = 1'b1;
            w_acc_nxt   = '0;
            w_k_nxt     = '0;
            w_state_nxt = S_MAC;
          end
        end
        S_MAC: begin
          w_acc_nxt = r_acc + ACC_W'(w_prod);
          w_k_nxt   = r_k + AW'(1);
          if (r_k == LAST_TAP) begin
            w_state_nxt = S_ROUND;
          end
        end
        S_ROUND: begin
          w_out_data_nxt  = DW'(w_sat);
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k         <= '0;
      r_acc       <= '0;
      r_wr_ptr    <= '0;
      r_newest    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_coef_ack  <= 1'b0;
    end else begin
      r_k         <= w_k_nxt;
      r_acc       <= w_acc_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_coef_ack  <= w_accept_coef;
      if (w_accept_in) begin
        r_newest <= r_wr_ptr;
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
    end
  end

  // Coefficient bank and delay line; both clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        r_coef[i] <= '0;
        r_x[i]    <= '0;
      end
    end else begin
      if (w_accept_coef) begin
        r_coef[coef_addr] <= coef_data;
      end
      if (w_accept_in) begin
        r_x[r_wr_ptr] <= in_data;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign coef_ack  = r_coef_ack;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed controller for the FIR datapath. It holds the coefficient bank and sample delay line, accepts one input sample per valid/ready handshake, and steps a single shared multiplier across all taps. It then rounds/saturates the accumulated sum and presents the result on a valid/ready output. It sits between the pin-level input logic and the output pins inside the filter top level, and replaces one-multiplier-per-tap hardware.

## Interface

Parameters:
- TAPS, 4, number of filter taps (≥2, power of two)
- DW, 8, signed sample/output width
- CW, 8, signed coefficient width
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation
- Derived: AW = clog2(TAPS); ACC_W = DW+CW+AW

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  design enable; low freezes the block
- in_valid  in  1  input sample offered
- in_ready  out  1  block can accept a sample
- in_data  in  DW  signed input sample
- coef_we  in  1  coefficient write request
- coef_addr  in  AW  tap index to write
- coef_data  in  CW  signed coefficient value
- coef_ack  out  1  one-cycle pulse: the write was accepted
- out_valid  out  1  filtered result available
- out_ready  in  1  consumer accepts result
- out_data  out  DW  signed filtered result

## Operation

- Storage: coef[0..TAPS-1], delay line x[0..TAPS-1], write pointer wr_ptr (AW bits, wraps modulo TAPS), tap counter k, accumulator acc (ACC_W, signed).
- Definition: y[n] = Σ_{k=0..TAPS-1} coef[k]·x[n−k]. The delay-line index for tap k is (wr_ptr_of_newest − k) mod TAPS.
- States: IDLE, MAC, ROUND, HOLD.
- IDLE: in_ready = ena.
  - On in_valid & in_ready: x[wr_ptr] ← in_data, remember that slot as the newest, wr_ptr ← wr_ptr+1, acc ← 0, k ← 0, go to MAC.
- MAC: each cycle acc ← acc + coef[k]·x[newest−k] (full-width signed product DW+CW, sign-extended), k ← k+1. After the k = TAPS−1 update, go to ROUND.
- ROUND: t = acc >>> SHIFT.
  - Saturate t to [−2^(DW−1), 2^(DW−1)−1] and register it into out_data.
  - out_valid ← 1, go to HOLD.
- HOLD: out_valid = 1 and out_data held stable. On out_ready, out_valid ← 0 and go to IDLE. out_data keeps its last value after the handshake.
- Coefficient writes are accepted only when state = IDLE and ena = 1. An accepted write updates coef[coef_addr] at the edge and pulses coef_ack for the following cycle.
  - Writes in any other state or with ena = 0 are dropped, with no coef_ack.
- Simultaneous coef_we and input handshake in IDLE: both are accepted. The new coefficient is in effect for that sample's MAC pass.
- ena = 0: state, k, acc, the delay line and the outputs all hold. in_ready = 0. out_valid keeps its value. Processing resumes where it stopped once ena = 1.
- in_valid in any state other than IDLE is ignored (in_ready = 0).
- Reset (async, any state, including mid-MAC):
  - state ← IDLE; coef, x, wr_ptr, k and acc ← 0.
  - out_valid = 0, out_data = 0, coef_ack = 0.
  - in_ready = ena right after release.

## Timing

- Input handshake at edge E0. MAC updates occur on edges E1..E_TAPS. ROUND registers the result at edge E(TAPS+1), so out_valid is high from E(TAPS+1) onward.
- Latency from input handshake to out_valid = TAPS+1 cycles (5 for defaults).
- Minimum sample period = TAPS+3 cycles (one IDLE cycle, TAPS MAC cycles, one ROUND cycle, one HOLD cycle with out_ready = 1).
- in_ready is combinational from state and ena only, never from in_valid. out_valid is registered.
- coef_ack is registered: it is high exactly one cycle, starting at the edge that performs the write.

## Test plan

Defaults: TAPS=4, DW=CW=8, SHIFT=0, ena=1 unless stated.

- Reset: assert rst_n=0 mid-run → out_valid=0, out_data=0, coef_ack=0 immediately. After release, in_ready=1 and a sample of 100 gives out_data=0, because the coefficients are cleared.
- Impulse: write coef = {1,2,3,4} and check 4 coef_ack pulses. Feed 1,0,0,0 with out_ready=1 → out_data = 1,2,3,4. out_valid rises 5 cycles after each input handshake.
- Saturation: coef all 127, feed 127 → 127. coef all 127, feed −128 → −128. With SHIFT=7 and coef[0]=64, others 0, feed 100 → 50.
- Backpressure: out_ready=0 for 10 cycles → out_valid stays 1 and out_data is stable. in_ready=0, and a coef_we during HOLD gives no coef_ack and leaves the coefficient unchanged. Raising out_ready returns to IDLE and the next sample is accepted.
- Enable freeze: drop ena for 6 cycles during MAC → no state progress, in_ready=0. After ena returns, the result equals the unfrozen result and out_valid arrives 6 cycles later than nominal.
- Wrap/simultaneous: feed 6 samples so wr_ptr wraps → outputs match the reference convolution. Issue coef_we(addr0, 2) in the same cycle as the input handshake → the result uses coef[0]=2 and coef_ack pulses.
